// File: rtl/fir_mc_ctrl_if.sv
// Handshake and RAM/MAC control bundle for fir_mc_ctrl.
// FIR_SYM_FOLD_EN adds the second read address and the fold flag.
interface fir_mc_ctrl_if #(
    parameter int CW = 1,
    parameter int AW = 6
);
    logic              in_valid;
    logic [CW-1:0]     in_ch;
    logic              in_ready;
    logic              wr_en;
    logic [CW+AW-1:0]  wr_addr;
    logic              rd_en;
    logic [CW+AW-1:0]  rd_addr;
    logic [AW-1:0]     coef_addr;
    logic              acc_clr;
    logic              mac_en;
    logic              out_valid;
    logic [CW-1:0]     out_ch;
    logic              out_ready;
    logic              busy;
    logic              err_ch;
`ifdef FIR_SYM_FOLD_EN
    logic [CW+AW-1:0]  rd_addr_b;
    logic              fold;

    modport master (
        input  in_valid, in_ch, out_ready,
        output in_ready, wr_en, wr_addr, rd_en, rd_addr, coef_addr, acc_clr,
               mac_en, out_valid, out_ch, busy, err_ch, rd_addr_b, fold
    );
    modport slave (
        output in_valid, in_ch, out_ready,
        input  in_ready, wr_en, wr_addr, rd_en, rd_addr, coef_addr, acc_clr,
               mac_en, out_valid, out_ch, busy, err_ch, rd_addr_b, fold
    );
`else
    modport master (
        input  in_valid, in_ch, out_ready,
        output in_ready, wr_en, wr_addr, rd_en, rd_addr, coef_addr, acc_clr,
               mac_en, out_valid, out_ch, busy, err_ch
    );
    modport slave (
        output in_valid, in_ch, out_ready,
        input  in_ready, wr_en, wr_addr, rd_en, rd_addr, coef_addr, acc_clr,
               mac_en, out_valid, out_ch, busy, err_ch
    );
`endif
endinterface

// File: rtl/fir_mc_ctrl.sv
// Multi-channel FIR control unit: per-channel circular delay-line write, tap read and MAC sequencing.
// Optional symmetric folding (two reads per MAC cycle) is enabled by defining FIR_SYM_FOLD_EN.
module fir_mc_ctrl #(
    parameter int TAPS = 64,
    parameter int CH   = 2,
    parameter int AW   = $clog2(TAPS),
    parameter int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    fir_mc_ctrl_if.master bus
);
    // Handshakes: a sample is taken when in_valid & in_ready are high on a rising edge;
    // a result is released when out_valid & out_ready are high on a rising edge.

    localparam logic [AW:0] TAPS_W    = (AW + 1)'(TAPS);
    localparam logic [AW:0] TAPS_M1_W = (AW + 1)'(TAPS - 1);
`ifdef FIR_SYM_FOLD_EN
    localparam int NMAC     = (TAPS + 1) / 2;
    localparam bit TAPS_ODD = (TAPS % 2) == 1;
`else
    localparam int NMAC = TAPS;
`endif
    localparam logic [AW-1:0] LAST_J   = AW'(NMAC - 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PRIME, S_MAC, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] wp_q [CH];
    logic [AW-1:0] wp_d [CH];
    logic          rdy_en_q;
    logic          err_q, err_d;

    logic          accept;
    logic          bad_ch;
    logic [AW-1:0] wp_sel;
    logic [AW:0]   rd_tap;

    // (a - off) mod TAPS with off in 0..TAPS-1; works for non-power-of-two TAPS.
    function automatic logic [AW-1:0] sub_mod(input logic [AW-1:0] a, input logic [AW:0] off);
        logic [AW:0] a_w;
        a_w = {1'b0, a};
        if (a_w >= off) sub_mod = AW'(a_w - off);
        else            sub_mod = AW'(a_w + TAPS_W - off);
    endfunction

    // rdy_en_q keeps in_ready low while reset is asserted and for the first edge after it.
    assign accept = (state_q == S_IDLE) && rdy_en_q && bus.in_valid;
    assign bad_ch = int'(bus.in_ch) >= CH;
    assign rd_tap = (state_q == S_PRIME) ? '0 : ({1'b0, j_q} + 1'b1);

    always_comb begin
        wp_sel = '0;
        for (int c = 0; c < CH; c++) begin
            if (ch_q == CW'(c)) wp_sel = wp_q[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            base_q   <= '0;
            j_q      <= '0;
            rdy_en_q <= 1'b0;
            err_q    <= 1'b0;
            for (int c = 0; c < CH; c++) wp_q[c] <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            base_q   <= base_d;
            j_q      <= j_d;
            rdy_en_q <= 1'b1;
            err_q    <= err_d;
            for (int c = 0; c < CH; c++) wp_q[c] <= wp_d[c];
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        base_d  = base_q;
        j_d     = j_q;
        err_d   = 1'b0;
        for (int c = 0; c < CH; c++) wp_d[c] = wp_q[c];
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad_ch) begin
                        err_d = 1'b1;
                    end else begin
                        ch_d    = bus.in_ch;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                base_d = wp_sel;
                for (int c = 0; c < CH; c++) begin
                    if (ch_q == CW'(c)) wp_d[c] = (wp_sel == LAST_PTR) ? '0 : wp_sel + 1'b1;
                end
                state_d = S_PRIME;
            end
            S_PRIME: begin
                j_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (j_q == LAST_J) state_d = S_DONE;
                else               j_d     = j_q + 1'b1;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.coef_addr = '0;
        bus.acc_clr   = 1'b0;
        bus.mac_en    = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_ch    = '0;
`ifdef FIR_SYM_FOLD_EN
        bus.rd_addr_b = '0;
        bus.fold      = 1'b0;
`endif
        case (state_q)
            S_IDLE: bus.in_ready = rdy_en_q;
            S_LOAD: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = {ch_q, wp_sel};
                bus.acc_clr = 1'b1;
            end
            S_PRIME: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = {ch_q, sub_mod(base_q, rd_tap)};
`ifdef FIR_SYM_FOLD_EN
                bus.rd_addr_b = {ch_q, sub_mod(base_q, TAPS_M1_W - rd_tap)};
`endif
            end
            S_MAC: begin
                bus.mac_en    = 1'b1;
                bus.coef_addr = j_q;
                // Each MAC cycle prefetches the next tap so data meets its coefficient one cycle later.
                if (j_q != LAST_J) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = {ch_q, sub_mod(base_q, rd_tap)};
`ifdef FIR_SYM_FOLD_EN
                    bus.rd_addr_b = {ch_q, sub_mod(base_q, TAPS_M1_W - rd_tap)};
`endif
                end
`ifdef FIR_SYM_FOLD_EN
                bus.fold = !(TAPS_ODD && (j_q == LAST_J));
`endif
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_ch    = ch_q;
            end
            default: ;
        endcase
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.err_ch = err_q;

endmodule

// File: tb/tb_fir_mc_ctrl.sv
// Directed bench for fir_mc_ctrl (TAPS=4, CH=2, CW=2; TAPS=5 when FIR_SYM_FOLD_EN is defined).
module tb_fir_mc_ctrl;
`ifdef FIR_SYM_FOLD_EN
  localparam int TAPS = 5;
  localparam int NMAC = 3;
`else
  localparam int TAPS = 4;
  localparam int NMAC = 4;
`endif
  localparam int CH = 2;
  localparam int CW = 2;
  localparam int AW = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int wp_m [CH];

  always #5 clk = ~clk;

  fir_mc_ctrl_if #(.CW(CW), .AW(AW)) bus ();
  fir_mc_ctrl #(.TAPS(TAPS), .CH(CH), .AW(AW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr(input int ch, input int p);
    return 32'((ch << AW) | p);
  endfunction

  function automatic int smod(input int p, input int o);
    return ((p - o) % TAPS + TAPS) % TAPS;
  endfunction

  // One full request on channel ch; hold = cycles out_ready stays low in DONE.
  task automatic do_req(input int ch, input int hold);
    int p;
    p = wp_m[ch];
    wp_m[ch] = (p == TAPS - 1) ? 0 : p + 1;
    bus.out_ready = (hold == 0);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_ch = CW'(ch);
    step;
    bus.in_valid = 1'b0;
    chk("load_wr_en", 32'(bus.wr_en), 1);
    chk("load_wr_addr", 32'(bus.wr_addr), addr(ch, p));
    chk("load_acc_clr", 32'(bus.acc_clr), 1);
    chk("load_in_ready", 32'(bus.in_ready), 0);
    chk("load_busy", 32'(bus.busy), 1);
    step;
    chk("prime_rd_en", 32'(bus.rd_en), 1);
    chk("prime_rd_addr", 32'(bus.rd_addr), addr(ch, p));
    chk("prime_wr_en", 32'(bus.wr_en), 0);
`ifdef FIR_SYM_FOLD_EN
    chk("prime_rd_addr_b", 32'(bus.rd_addr_b), addr(ch, smod(p, TAPS - 1)));
`endif
    for (int k = 0; k < NMAC; k++) begin
      step;
      chk("mac_en", 32'(bus.mac_en), 1);
      chk("mac_coef_addr", 32'(bus.coef_addr), k);
      chk("mac_out_valid", 32'(bus.out_valid), 0);
      chk("mac_rd_en", 32'(bus.rd_en), (k < NMAC - 1) ? 1 : 0);
      if (k < NMAC - 1) begin
        chk("mac_rd_addr", 32'(bus.rd_addr), addr(ch, smod(p, k + 1)));
`ifdef FIR_SYM_FOLD_EN
        chk("mac_rd_addr_b", 32'(bus.rd_addr_b), addr(ch, smod(p, TAPS - 1 - (k + 1))));
`endif
      end
`ifdef FIR_SYM_FOLD_EN
      chk("mac_fold", 32'(bus.fold), (k == NMAC - 1 && (TAPS % 2) == 1) ? 0 : 1);
`endif
    end
    step;
    chk("done_out_valid", 32'(bus.out_valid), 1);
    chk("done_out_ch", 32'(bus.out_ch), ch);
    chk("done_mac_en", 32'(bus.mac_en), 0);
    for (int n = 0; n < hold; n++) begin
      bus.in_valid = 1'b1;
      bus.in_ch = CW'(ch ^ 1);
      step;
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_out_ch", 32'(bus.out_ch), ch);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      chk("hold_wr_en", 32'(bus.wr_en), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step;
    chk("post_out_valid", 32'(bus.out_valid), 0);
    chk("post_in_ready", 32'(bus.in_ready), 1);
    chk("post_busy", 32'(bus.busy), 0);
  endtask

  task automatic chk_all_zero(input string phase);
    chk({phase, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({phase, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({phase, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({phase, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({phase, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({phase, "_coef_addr"}, 32'(bus.coef_addr), 0);
    chk({phase, "_acc_clr"}, 32'(bus.acc_clr), 0);
    chk({phase, "_mac_en"}, 32'(bus.mac_en), 0);
    chk({phase, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({phase, "_out_ch"}, 32'(bus.out_ch), 0);
    chk({phase, "_busy"}, 32'(bus.busy), 0);
    chk({phase, "_err_ch"}, 32'(bus.err_ch), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ch = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < CH; c++) wp_m[c] = 0;

    // Reset state
    step;
    step;
    chk_all_zero("rst");
    rst = 1'b0;
    step;
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // First ch0 request, then one held in DONE for 10 cycles
    do_req(0, 0);
    do_req(0, 10);

    // Remaining ch0 requests wrap the pointer, then ch1 starts at 0
    do_req(0, 0);
    do_req(0, 0);
    do_req(0, 0);
    do_req(1, 0);

    // Out-of-range channel: dropped with a one-cycle error pulse
    bus.in_valid = 1'b1;
    bus.in_ch = 2'd3;
    step;
    bus.in_valid = 1'b0;
    chk("err_pulse", 32'(bus.err_ch), 1);
    chk("err_wr_en", 32'(bus.wr_en), 0);
    chk("err_busy", 32'(bus.busy), 0);
    chk("err_in_ready", 32'(bus.in_ready), 1);
    step;
    chk("err_clear", 32'(bus.err_ch), 0);
    chk("err_busy2", 32'(bus.busy), 0);
    chk("err_wr_en2", 32'(bus.wr_en), 0);

    // Pointers are untouched by the dropped request
    do_req(0, 0);
    do_req(1, 0);

    // Asynchronous reset in the middle of MAC
    bus.in_valid = 1'b1;
    bus.in_ch = 2'd1;
    step;
    bus.in_valid = 1'b0;
    step;
    step;
    chk("pre_rst_mac_en", 32'(bus.mac_en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    for (int c = 0; c < CH; c++) wp_m[c] = 0;
    for (int n = 0; n < 3; n++) begin
      step;
      chk("in_rst_out_valid", 32'(bus.out_valid), 0);
    end
    rst = 1'b0;
    step;
    step;
    do_req(1, 0);
    do_req(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
